dataflow_array: RTL and testbench

Parametrised successor to the 4-PE non-von-Neumann processor. Accepts a program of up to NUM_PE 2-operand instructions over a valid/ready handshake and issues instruction k to PE k. Each operand is an immediate or the registered output of a strictly earlier PE. The final PE's value is returned over a valid/ready result port, with a sticky fault flag for illegal operand references.

---
 rtl/dataflow_pkg.sv | 20 ++
 rtl/dataflow_pe.sv | 53 +++++
 rtl/dataflow_array.sv | 131 +++++++++++++
 tb/tb_dataflow_array.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dataflow_pkg.sv
// Shared types and helpers for the dataflow array and its processing elements.
package dataflow_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_t;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  function automatic int instr_w(input int data_w);
    return 2 * data_w + 4;
  endfunction

endpackage

// File: rtl/dataflow_pe.sv
// One processing element: 2-operand ALU feeding a DATA_W-bit register with enable/clear.
// Optional feature: DATAFLOW_ARRAY_SATURATE_EN makes ADD/SUB clamp instead of wrap.
module dataflow_pe
  import dataflow_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [1:0]        i_alu_op,
  output logic [DATA_W-1:0] o_alu,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] r_q;

  // Extra MSB carries the carry-out (ADD) or borrow (SUB).
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_alu = '0;
    case (alu_op_t'(i_alu_op))
`ifdef DATAFLOW_ARRAY_SATURATE_EN
      ALU_ADD: o_alu = w_sum[DATA_W]  ? '1 : w_sum[DATA_W-1:0];
      ALU_SUB: o_alu = w_diff[DATA_W] ? '0 : w_diff[DATA_W-1:0];
`else
      ALU_ADD: o_alu = w_sum[DATA_W-1:0];
      ALU_SUB: o_alu = w_diff[DATA_W-1:0];
`endif
      ALU_AND: o_alu = i_a & i_b;
      ALU_XOR: o_alu = i_a ^ i_b;
      default: o_alu = '0;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= o_alu;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/dataflow_array.sv
// Dataflow array top: loads a program of up to NUM_PE instructions, one per PE,
// and returns the last PE's value with a sticky illegal-reference fault flag.
module dataflow_array
  import dataflow_pkg::*;
#(
  parameter int NUM_PE  = 8,
  parameter int DATA_W  = 4,
  localparam int INSTR_W = instr_w(DATA_W)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_instr_valid,
  input  logic               i_instr_last,
  output logic               o_instr_ready,
  output logic [DATA_W-1:0]  o_result,
  output logic               o_result_valid,
  output logic               o_result_fault,
  input  logic               i_result_ready
);

  localparam int SLOT_W = $clog2(NUM_PE);

  state_t              r_state;
  state_t              w_state_next;
  logic [SLOT_W-1:0]   r_slot;
  logic                r_fault_sticky;
  logic [DATA_W-1:0]   r_result;
  logic                r_result_fault;

  logic [DATA_W-1:0]   w_pe_q   [NUM_PE];
  logic [DATA_W-1:0]   w_pe_alu [NUM_PE];

  logic [DATA_W-1:0]   w_op0;
  logic [DATA_W-1:0]   w_op1;
  logic                w_imm0;
  logic                w_imm1;
  logic [1:0]          w_alu_op;
  logic                w_bad0;
  logic                w_bad1;
  logic                w_fault;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_accept;
  logic                w_last;
  logic                w_handoff;

  assign w_op0    = i_instr[INSTR_W-1 -: DATA_W];
  assign w_op1    = i_instr[INSTR_W-1-DATA_W -: DATA_W];
  assign w_imm0   = i_instr[3];
  assign w_imm1   = i_instr[2];
  assign w_alu_op = i_instr[1:0];

  // A register reference is legal only if it names an already-written PE.
  assign w_bad0 = !w_imm0 && (((w_op0 >> SLOT_W) != '0) || (w_op0[SLOT_W-1:0] >= r_slot));
  assign w_bad1 = !w_imm1 && (((w_op1 >> SLOT_W) != '0) || (w_op1[SLOT_W-1:0] >= r_slot));
  assign w_fault = w_bad0 || w_bad1;

  assign w_a = w_imm0 ? w_op0 : w_pe_q[w_op0[SLOT_W-1:0]];
  assign w_b = w_imm1 ? w_op1 : w_pe_q[w_op1[SLOT_W-1:0]];

  assign w_accept  = i_instr_valid && (r_state == ST_LOAD);
  assign w_last    = i_instr_last || (r_slot == SLOT_W'(NUM_PE - 1));
  assign w_handoff = (r_state == ST_DONE) && i_result_ready;
  assign w_wdata   = w_fault ? '0 : w_pe_alu[r_slot];

  for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
    logic w_sel;
    assign w_sel = w_accept && (r_slot == SLOT_W'(k));

    dataflow_pe #(
      .DATA_W (DATA_W)
    ) u_pe (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_en     (w_sel),
      .i_clear  (w_handoff || (w_sel && w_fault)),
      .i_a      (w_a),
      .i_b      (w_b),
      .i_alu_op (w_alu_op),
      .o_alu    (w_pe_alu[k]),
      .o_q      (w_pe_q[k])
    );
  end

  always_comb begin
    w_state_next   = r_state;
    o_instr_ready  = 1'b0;
    o_result_valid = 1'b0;
    case (r_state)
      ST_LOAD: begin
        o_instr_ready = 1'b1;
        if (w_accept && w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        o_result_valid = 1'b1;
        if (i_result_ready) w_state_next = ST_LOAD;
      end
      default: w_state_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= ST_LOAD;
      r_slot         <= '0;
      r_fault_sticky <= 1'b0;
      r_result       <= '0;
      r_result_fault <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_handoff) begin
        r_slot         <= '0;
        r_fault_sticky <= 1'b0;
      end else if (w_accept) begin
        r_fault_sticky <= r_fault_sticky || w_fault;
        if (w_last) begin
          r_result       <= w_wdata;
          r_result_fault <= r_fault_sticky || w_fault;
        end else begin
          r_slot <= r_slot + 1'b1;
        end
      end
    end
  end

  assign o_result       = r_result;
  assign o_result_fault = r_result_fault;

endmodule

// File: tb/tb_dataflow_array.sv
// Directed, table-driven checks for dataflow_array (NUM_PE=8, DATA_W=4).
module tb_dataflow_array;

  localparam int NUM_PE  = 8;
  localparam int DATA_W  = 4;
  localparam int INSTR_W = 2 * DATA_W + 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [INSTR_W-1:0] i_instr = '0;
  logic               i_valid = 1'b0;
  logic               i_last  = 1'b0;
  logic               o_ready;
  logic [DATA_W-1:0]  o_result;
  logic               o_valid;
  logic               o_fault;
  logic               i_rready = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic       ia;
    logic       ib;
    logic [1:0] op;
    int         exp;
    int         expf;
  } vec_t;

  vec_t vecs[9];

  dataflow_array #(
    .NUM_PE (NUM_PE),
    .DATA_W (DATA_W)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_instr        (i_instr),
    .i_instr_valid  (i_valid),
    .i_instr_last   (i_last),
    .o_instr_ready  (o_ready),
    .o_result       (o_result),
    .o_result_valid (o_valid),
    .o_result_fault (o_fault),
    .i_result_ready (i_rready)
  );

  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] mk(input logic [3:0] a, input logic [3:0] b,
                                            input logic ia, input logic ib, input logic [1:0] op);
    return {a, b, ia, ib, op};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [INSTR_W-1:0] ins, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    i_instr = ins;
    i_valid = 1'b1;
    i_last  = last;
    while (!o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic take_result(input string name, input int exp, input int expf);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, int'(o_valid), 1);
    chk({name, "_result"}, int'(o_result), exp);
    chk({name, "_fault"}, int'(o_fault), expf);
    i_rready = 1'b1;
    @(posedge clk);
    #1;
    i_rready = 1'b0;
    chk({name, "_released"}, int'(o_valid), 0);
    chk({name, "_ready_again"}, int'(o_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef DATAFLOW_ARRAY_SATURATE_EN
    vecs[0] = '{"add_5_6",    4'd5,  4'd6,  1'b1, 1'b1, 2'b00, 11, 0};
    vecs[1] = '{"sub_9_4",    4'd9,  4'd4,  1'b1, 1'b1, 2'b01, 5,  0};
    vecs[2] = '{"sub_3_5",    4'd3,  4'd5,  1'b1, 1'b1, 2'b01, 0,  0};
    vecs[3] = '{"and_12_10",  4'd12, 4'd10, 1'b1, 1'b1, 2'b10, 8,  0};
    vecs[4] = '{"xor_12_10",  4'd12, 4'd10, 1'b1, 1'b1, 2'b11, 6,  0};
    vecs[5] = '{"add_15_3",   4'd15, 4'd3,  1'b1, 1'b1, 2'b00, 15, 0};
    vecs[6] = '{"sub_1_2",    4'd1,  4'd2,  1'b1, 1'b1, 2'b01, 0,  0};
`else
    vecs[0] = '{"add_5_6",    4'd5,  4'd6,  1'b1, 1'b1, 2'b00, 11, 0};
    vecs[1] = '{"sub_9_4",    4'd9,  4'd4,  1'b1, 1'b1, 2'b01, 5,  0};
    vecs[2] = '{"sub_3_5",    4'd3,  4'd5,  1'b1, 1'b1, 2'b01, 14, 0};
    vecs[3] = '{"and_12_10",  4'd12, 4'd10, 1'b1, 1'b1, 2'b10, 8,  0};
    vecs[4] = '{"xor_12_10",  4'd12, 4'd10, 1'b1, 1'b1, 2'b11, 6,  0};
    vecs[5] = '{"add_15_3",   4'd15, 4'd3,  1'b1, 1'b1, 2'b00, 2,  0};
    vecs[6] = '{"sub_1_2",    4'd1,  4'd2,  1'b1, 1'b1, 2'b01, 15, 0};
`endif
    vecs[7] = '{"ill_fwd_pe1", 4'd1, 4'd7,  1'b0, 1'b1, 2'b00, 0,  1};
    vecs[8] = '{"ill_hi_bit",  4'd7, 4'd8,  1'b1, 1'b0, 2'b11, 0,  1};

    repeat (2) @(negedge clk);
    chk("in_reset_ready", int'(o_ready), 1);
    chk("in_reset_valid", int'(o_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", int'(o_ready), 1);
    chk("reset_valid", int'(o_valid), 0);
    chk("reset_result", int'(o_result), 0);
    chk("reset_fault", int'(o_fault), 0);

    // instr_last without instr_valid must not end anything
    i_last = 1'b1;
    @(negedge clk);
    i_last = 1'b0;
    chk("last_no_valid", int'(o_valid), 0);

    // two-instruction chain: PE0=3+4, PE0+2
    send(mk(4'd3, 4'd4, 1'b1, 1'b1, 2'b00), 1'b0);
    chk("chain2_mid_valid", int'(o_valid), 0);
    send(mk(4'd0, 4'd2, 1'b0, 1'b1, 2'b00), 1'b1);
    chk("chain2_latency", int'(o_valid), 1);
    take_result("chain2", 9, 0);

    // full 8-PE chain without instr_last
    send(mk(4'd0, 4'd1, 1'b1, 1'b1, 2'b00), 1'b0);
    for (int k = 1; k < NUM_PE; k++) begin
      if (k == NUM_PE - 1) chk("chain8_pre_valid", int'(o_valid), 0);
      send(mk(4'(k - 1), 4'd1, 1'b0, 1'b1, 2'b00), 1'b0);
    end
    chk("chain8_latency", int'(o_valid), 1);
    take_result("chain8", 8, 0);

    // forward reference faults, PE0 holds 0; next program is clean
    send(mk(4'd2, 4'd1, 1'b0, 1'b1, 2'b00), 1'b0);
    send(mk(4'd0, 4'd5, 1'b0, 1'b1, 2'b00), 1'b1);
    take_result("fwdref", 5, 1);
    send(mk(4'd1, 4'd1, 1'b1, 1'b1, 2'b00), 1'b1);
    take_result("after_fault", 2, 0);

    for (int i = 0; i < 9; i++) begin
      send(mk(vecs[i].a, vecs[i].b, vecs[i].ia, vecs[i].ib, vecs[i].op), 1'b1);
      take_result(vecs[i].name, vecs[i].exp, vecs[i].expf);
    end

    // backpressure with a new instruction already waiting
    send(mk(4'd7, 4'd1, 1'b1, 1'b1, 2'b00), 1'b1);
    i_instr = mk(4'd2, 4'd2, 1'b1, 1'b1, 2'b00);
    i_valid = 1'b1;
    i_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_ready", int'(o_ready), 0);
      chk("bp_valid", int'(o_valid), 1);
      chk("bp_result", int'(o_result), 8);
    end
    @(negedge clk);
    i_rready = 1'b1;
    @(posedge clk);
    #1;
    i_rready = 1'b0;
    chk("bp_handoff_valid", int'(o_valid), 0);
    chk("bp_handoff_ready", int'(o_ready), 1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    chk("bp_next_accept", int'(o_valid), 1);
    take_result("bp_next", 4, 0);

    // reset mid-program, then a PE0 read at slot 0 is illegal
    send(mk(4'd1, 4'd1, 1'b1, 1'b1, 2'b00), 1'b0);
    send(mk(4'd2, 4'd1, 1'b1, 1'b1, 2'b00), 1'b0);
    send(mk(4'd3, 4'd1, 1'b1, 1'b1, 2'b00), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", int'(o_ready), 1);
    chk("midrst_valid", int'(o_valid), 0);
    send(mk(4'd0, 4'd3, 1'b0, 1'b1, 2'b00), 1'b1);
    take_result("midrst_pe0", 0, 1);

    // reset while a result is pending discards it
    send(mk(4'd5, 4'd5, 1'b1, 1'b1, 2'b00), 1'b1);
    chk("donerst_pre_valid", int'(o_valid), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("donerst_valid", int'(o_valid), 0);
    chk("donerst_result", int'(o_result), 0);
    chk("donerst_ready", int'(o_ready), 1);
    send(mk(4'd2, 4'd2, 1'b1, 1'b1, 2'b00), 1'b1);
    take_result("donerst_next", 4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
